// File: rtl/period_meter.sv
// period_meter
//   Measures period and high time of a slow asynchronous signal in Clk_in
//   cycles. sig_in passes through a 3-flop synchronizer; the third flop is
//   only used for edge detection.
// Ports:
//   Clk_in      system clock, rising edge
//   reset       async active-low reset
//   enable      measurement enable (sync to Clk_in)
//   sig_in      signal under measurement (async)
//   period      cycles between the last two rising edges of sig_in
//   high_time   cycles sig_in was high within that period
//   meas_valid  one-cycle pulse when period/high_time update
//   timeout     no rising edge within MAX cycles; sticky until next result
module period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, TMO} state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           st, nxt;
  logic             s1, s2, s3;
  logic             rise;
  logic [WIDTH-1:0] cnt, hcnt, cnt_d, hcnt_d, period_d, high_d;
  logic             valid_d, to_d;

  // synchronizer runs regardless of enable so edges are clean on re-arm
  always_ff @(posedge Clk_in or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // state register
  always_ff @(posedge Clk_in or negedge reset) begin
    if (!reset) st <= IDLE;
    else        st <= nxt;
  end

  // next state; enable low overrides everything, including a coincident rise
  always_comb begin
    nxt = st;
    if (!enable) nxt = IDLE;
    else begin
      case (st)
        IDLE:    nxt = ARM;
        ARM:     if (rise) nxt = MEASURE;
        MEASURE: if (!rise && cnt == MAX) nxt = TMO;
        TMO:     if (rise) nxt = MEASURE;
        default: nxt = IDLE;
      endcase
    end
  end

  // next values of counters and registered outputs
  always_comb begin
    cnt_d    = cnt;
    hcnt_d   = hcnt;
    period_d = period;
    high_d   = high_time;
    valid_d  = 1'b0;
    to_d     = timeout;
    if (!enable) begin
      cnt_d  = '0;
      hcnt_d = '0;
      to_d   = 1'b0;
    end else begin
      case (st)
        IDLE: begin
          cnt_d  = '0;
          hcnt_d = '0;
        end
        // the rise cycle itself is high, so hcnt restarts at 1
        ARM, TMO: begin
          if (rise) begin
            cnt_d  = ONE;
            hcnt_d = ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // a rise exactly at cnt==MAX still yields a valid MAX result
            period_d = cnt;
            high_d   = hcnt;
            valid_d  = 1'b1;
            to_d     = 1'b0;
            cnt_d    = ONE;
            hcnt_d   = ONE;
          end else if (cnt == MAX) begin
            to_d     = 1'b1;
            period_d = '0;
            high_d   = '0;
          end else begin
            cnt_d  = cnt + ONE;
            hcnt_d = hcnt + {{(WIDTH-1){1'b0}}, s2};
          end
        end
        default: begin
          cnt_d  = '0;
          hcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk_in or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      hcnt       <= hcnt_d;
      period     <= period_d;
      high_time  <= high_d;
      meas_valid <= valid_d;
      timeout    <= to_d;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: one WIDTH=16 and one WIDTH=8 instance share the
// same stimulus. A reference model derives results from rise times and
// prefix sums of high samples; a monitor checks outputs against it.
module tb_period_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sig = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] p16, h16;
  logic        mv16, to16;
  logic [7:0]  p8, h8;
  logic        mv8, to8;

  period_meter #(.WIDTH(16)) u16 (
    .Clk_in(clk), .reset(rst_n), .enable(en), .sig_in(sig),
    .period(p16), .high_time(h16), .meas_valid(mv16), .timeout(to16)
  );

  period_meter #(.WIDTH(8)) u8 (
    .Clk_in(clk), .reset(rst_n), .enable(en), .sig_in(sig),
    .period(p8), .high_time(h8), .meas_valid(mv8), .timeout(to8)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int c; int p; int h; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // ---------------- reference model ----------------
  int cyc = 0;
  bit v1, v2, v3;     // samples taken 1, 2, 3 edges ago
  int ones;           // count of samples that have reached the edge detector
  bit rise_m;
  int maxv[2]   = '{65535, 255};
  bit armed[2];
  bit have_prev[2];
  bit tmo_st[2];
  bit exp_to[2];
  int prev[2], sprev[2], exp_p[2], exp_h[2];

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      v1 = 0; v2 = 0; v3 = 0; ones = 0;
      for (int d = 0; d < 2; d++) begin
        armed[d] = 0; have_prev[d] = 0; tmo_st[d] = 0; exp_to[d] = 0;
        prev[d] = 0; sprev[d] = 0; exp_p[d] = 0; exp_h[d] = 0;
      end
      q0.delete();
      q1.delete();
    end else begin
      rise_m = v2 && !v3;
      ones += int'(v3);
      for (int d = 0; d < 2; d++) begin
        if (!en) begin
          armed[d] = 0; have_prev[d] = 0; tmo_st[d] = 0; exp_to[d] = 0;
        end else if (!armed[d]) begin
          armed[d] = 1;
        end else if (rise_m) begin
          if (have_prev[d] && !tmo_st[d]) begin
            e = '{cyc, cyc - prev[d], ones - sprev[d]};
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            exp_p[d] = e.p; exp_h[d] = e.h; exp_to[d] = 0;
          end
          have_prev[d] = 1; tmo_st[d] = 0; prev[d] = cyc; sprev[d] = ones;
        end else if (have_prev[d] && !tmo_st[d] && cyc - prev[d] == maxv[d]) begin
          tmo_st[d] = 1; exp_to[d] = 1; exp_p[d] = 0; exp_h[d] = 0;
        end
      end
      v3 = v2; v2 = v1; v1 = sig;
    end
  end

  // ---------------- monitor ----------------
  task automatic chk_dut(input int d, input int ap, input int ah, input bit amv, input bit ato);
    exp_t e;
    int   n;
    checks++;
    if (ap != exp_p[d] || ah != exp_h[d]) begin
      errors++;
      $display("FAIL outputs w%0d cyc %0d period/high got %0d/%0d want %0d/%0d",
               d == 0 ? 16 : 8, cyc, ap, ah, exp_p[d], exp_h[d]);
    end
    checks++;
    if (ato != exp_to[d]) begin
      errors++;
      $display("FAIL timeout w%0d cyc %0d got %0d want %0d", d == 0 ? 16 : 8, cyc, ato, exp_to[d]);
    end
    n = (d == 0) ? q0.size() : q1.size();
    if (amv) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL meas_valid w%0d cyc %0d got pulse want none", d == 0 ? 16 : 8, cyc);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (e.c != cyc || e.p != ap || e.h != ah) begin
          errors++;
          $display("FAIL meas w%0d got cyc %0d p %0d h %0d want cyc %0d p %0d h %0d",
                   d == 0 ? 16 : 8, cyc, ap, ah, e.c, e.p, e.h);
        end
      end
    end else if (n > 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.c <= cyc) begin
        checks++;
        errors++;
        $display("FAIL meas_valid w%0d cyc %0d got none want pulse p %0d h %0d",
                 d == 0 ? 16 : 8, cyc, e.p, e.h);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk_dut(0, int'(p16), int'(h16), mv16, to16);
    chk_dut(1, int'(p8), int'(h8), mv8, to8);
  end

  // ---------------- stimulus ----------------
  task automatic chk_zero(input string tag);
    checks++;
    if (p16 != 0 || h16 != 0 || mv16 || to16 || p8 != 0 || h8 != 0 || mv8 || to8) begin
      errors++;
      $display("FAIL %s got p16 %0d h16 %0d mv16 %0d to16 %0d p8 %0d h8 %0d mv8 %0d to8 %0d want all 0",
               tag, p16, h16, mv16, to16, p8, h8, mv8, to8);
    end
  endtask

  task automatic drv(input bit v);
    @(negedge clk);
    sig = v;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++) drv(j < h);
  endtask

  initial begin
    int p, h;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;
    en    = 1'b1;

    wave(50, 25, 6);          // divider output
    wave(10, 3, 5);           // duty
    wave(7, 1, 6);            // narrow pulse
    repeat (300) drv(1'b0);   // stall: 8-bit instance times out
    wave(20, 10, 4);          // resume
    wave(255, 100, 3);        // saturation boundary, still valid at 8 bits
    wave(256, 128, 3);        // one past boundary
    wave(20, 5, 3);

    repeat (12) begin
      p = $urandom_range(40, 2);
      h = $urandom_range(p - 1, 1);
      wave(p, h, $urandom_range(4, 2));
    end

    // enable drop mid-period
    wave(30, 15, 3);
    for (int j = 0; j < 12; j++) drv(j < 15);
    en = 1'b0;
    repeat (5) drv(1'b0);
    en = 1'b1;
    wave(30, 15, 4);

    // async reset between edges while measuring period 50
    wave(50, 25, 3);
    for (int j = 0; j < 20; j++) drv(j < 25);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wave(50, 25, 4);
    repeat (5) drv(1'b0);

    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d/%0d outstanding want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous digital signal in cycles of the system clock. It is the receiving end of the clock-divider path: it recovers the divide ratio and duty cycle from a divided clock (e.g. 1 MHz from 50 MHz reads back as period 50, high time 25). It is used for self-check of divider outputs and for measuring external pulse trains. The block has one clock domain. The input signal is synchronized internally.

## Interface
- WIDTH, 16, width of the cycle counters and of the `period`/`high_time` outputs; MAX = 2^WIDTH-1
- Clk_in  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- enable  input  1  measurement enable, synchronous to Clk_in
- sig_in  input  1  signal under measurement, asynchronous to Clk_in
- period  output  WIDTH  Clk_in cycles between the last two rising edges of sig_in
- high_time  output  WIDTH  Clk_in cycles sig_in was high within that period
- meas_valid  output  1  one-cycle pulse when `period`/`high_time` update with a valid measurement
- timeout  output  1  no rising edge seen within MAX cycles; sticky until the next valid measurement

One clock; reset is asynchronous and active-low (ports Clk_in and reset).

## Operation
- **Synchronizer:** s1<=sig_in, s2<=s1, s3<=s2. `rise` = s2 & ~s3. All measurement logic uses s2 only.
- **Registers:** counters `cnt` and `hcnt` (WIDTH bits each) and a state register.
- **States and transitions:**
  - IDLE: `cnt`=0, `hcnt`=0. enable=1 -> ARM.
  - ARM: wait for the first `rise`. Any partial interval before it is discarded. On `rise`: `cnt`<=1, `hcnt`<=1, go to MEASURE.
  - MEASURE, no `rise`: `cnt`<=`cnt`+1, `hcnt`<=`hcnt`+s2.
  - MEASURE, `rise`: `period`<=`cnt`, `high_time`<=`hcnt`, meas_valid<=1 (one cycle), timeout<=0, `cnt`<=1, `hcnt`<=1. Stay in MEASURE.
  - MEASURE, no `rise` and `cnt`==MAX: go to TIMEOUT, timeout<=1, `period`<=0, `high_time`<=0.
  - TIMEOUT: counters held. On `rise`: `cnt`<=1, `hcnt`<=1, go to MEASURE. timeout stays 1 until the next meas_valid.
  - Any state with enable=0: go to IDLE next cycle. meas_valid<=0, timeout<=0. `period`/`high_time` retain their last values.
- **Simultaneous events:**
  - `rise` in the same cycle `cnt`==MAX: `rise` wins. Valid measurement with `period`=MAX.
  - enable falling in the same cycle as `rise`: enable wins. No meas_valid.
- **Arithmetic:** unsigned. `hcnt` <= `cnt` always. No wrap can occur because of the MAX check.
- **Resolution:** periods 2..MAX are measurable. High or low phases shorter than 1 Clk_in cycle may be missed, which is inherent to sampling.
- **Reset:** an active reset at any time forces IDLE and clears everything. `period`=0, `high_time`=0, meas_valid=0, timeout=0, s1..s3=0, counters=0.

## Timing
- **Input latency:** a sig_in rising edge settling before Clk_in edge k is seen in s1 at edge k and in s2 at edge k+1. `rise` is high during the cycle after edge k+1 and is acted on at edge k+2.
- **Measurement latency:** the outputs and meas_valid are registered and change at edge k+2 of the closing rising edge.
- **First result:** the first meas_valid follows the second synchronized rising edge after entering ARM. ARM is entered one cycle after enable goes high.
- **Steady state:** for a stable input of period P, meas_valid pulses exactly every P cycles.
- **Timeout:** raised at the edge where `cnt` would exceed MAX, i.e. MAX cycles after the last registered `rise`.
- **Reset path:** reset assertion clears the outputs asynchronously. Deassertion takes effect at the next Clk_in edge. The block is in IDLE, and then in ARM if enable=1.

## Test plan
- **Divider output:** WIDTH=16, enable=1, sig_in square wave with period 50 and 25 cycles high. Required: first meas_valid after the 2nd rising edge with `period`=50 and `high_time`=25, then meas_valid every 50 cycles with the same values and timeout=0.
- **Duty and narrow pulse:** sig_in with period 10 and 3 high gives `period`=10, `high_time`=3. Then 1-cycle-high pulses every 7 cycles give `period`=7, `high_time`=1.
- **Timeout:** WIDTH=8. sig_in stops low after a rising edge. Required: 255 cycles after that registered `rise`, timeout=1 and `period`=`high_time`=0, with no meas_valid. Then resume a period-20 wave. Required: timeout stays 1 until the first meas_valid (`period`=20), then drops to 0 in that same cycle.
- **Saturation boundary:** WIDTH=8 and a period-255 input. Required: valid measurements with `period`=255 and timeout never set. A period-256 input must set timeout.
- **Enable drop:** deassert enable mid-period. Required: IDLE next cycle, no meas_valid, `period` holds its last value. On re-enable, meas_valid appears only after two fresh rising edges.
- **Reset mid-measurement:** assert reset asynchronously between clock edges while in MEASURE with `period`=50. Required: all outputs read 0 immediately. After release, behaviour matches a fresh start.
